// File: rtl/adc_rate_if.sv
// Control/status bundle between the ADC rate generator and its client.
// The _in/_out suffixes give the direction as seen from the generator.
interface adc_rate_if #(
    parameter int SEL_W = 3
);
    logic             enable_in;
    logic [SEL_W-1:0] sel_in;
    logic             sel_load_in;
    logic             adc_clk_out;
    logic             sample_stb_out;
    logic             running_out;
    logic [SEL_W-1:0] sel_active_out;
    logic             sel_busy_out;
    logic             sel_err_out;

    modport master (
        output enable_in, sel_in, sel_load_in,
        input  adc_clk_out, sample_stb_out, running_out,
        input  sel_active_out, sel_busy_out, sel_err_out
    );

    modport slave (
        input  enable_in, sel_in, sel_load_in,
        output adc_clk_out, sample_stb_out, running_out,
        output sel_active_out, sel_busy_out, sel_err_out
    );
endinterface

// File: rtl/adc_rate_gen.sv
// ADC conversion clock / sample strobe generator dividing clk_in by BASE_DIV*2^sel.
// Rate changes and start/stop are only honoured at period boundaries.
//
//   state | meaning
//   IDLE  | stopped, outputs low, pending rate applied immediately
//   RUN   | generating periods; rate/stop decisions made at cnt = div-1
module adc_rate_gen #(
    parameter int BASE_DIV  = 10,
    parameter int NUM_RATES = 8,
    parameter int SEL_W     = $clog2(NUM_RATES),
    parameter int CNT_W     = $clog2(BASE_DIV << (NUM_RATES - 1))
) (
    input  logic       clk_in,
    input  logic       rst_in,
    adc_rate_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W:0] ONE_W = (CNT_W + 1)'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             adc_clk, adc_clk_nxt;
    logic             stb, stb_nxt;
    logic [SEL_W-1:0] sel_active, sel_active_nxt;
    logic [SEL_W-1:0] sel_pend, sel_pend_nxt;
    logic             pend, pend_nxt;
    logic             sel_err, sel_err_nxt;
    logic [CNT_W:0]   div, half;
    logic             at_half, at_bound, sel_ok, apply;

    // One extra bit so the largest divisor itself is representable.
    assign div      = (CNT_W + 1)'(BASE_DIV) << sel_active;
    assign half     = div >> 1;
    assign at_half  = ({1'b0, cnt} == (half - ONE_W));
    assign at_bound = ({1'b0, cnt} == (div - ONE_W));
    assign sel_ok   = ({1'b0, bus.sel_in} < (SEL_W + 1)'(NUM_RATES));

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        adc_clk_nxt    = adc_clk;
        stb_nxt        = 1'b0;
        sel_active_nxt = sel_active;
        sel_pend_nxt   = sel_pend;
        pend_nxt       = pend;
        apply          = 1'b0;
        sel_err_nxt    = bus.sel_load_in && !sel_ok;

        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                adc_clk_nxt = 1'b0;
                apply       = pend;
                if (bus.enable_in) begin
                    state_nxt   = RUN;
                    adc_clk_nxt = 1'b1;
                    stb_nxt     = 1'b1;
                end
            end
            RUN: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (at_half) adc_clk_nxt = 1'b0;
                if (at_bound) begin
                    cnt_nxt = '0;
                    apply   = pend;
                    if (bus.enable_in) begin
                        adc_clk_nxt = 1'b1;
                        stb_nxt     = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        adc_clk_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The boundary consumes the value registered before this cycle's load.
        if (apply) begin
            sel_active_nxt = sel_pend;
            pend_nxt       = 1'b0;
        end
        if (bus.sel_load_in && sel_ok) begin
            sel_pend_nxt = bus.sel_in;
            pend_nxt     = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            cnt        <= '0;
            adc_clk    <= 1'b0;
            stb        <= 1'b0;
            sel_active <= '0;
            sel_pend   <= '0;
            pend       <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            adc_clk    <= adc_clk_nxt;
            stb        <= stb_nxt;
            sel_active <= sel_active_nxt;
            sel_pend   <= sel_pend_nxt;
            pend       <= pend_nxt;
            sel_err    <= sel_err_nxt;
        end
    end

    assign bus.adc_clk_out    = adc_clk;
    assign bus.sample_stb_out = stb;
    assign bus.running_out    = (state == RUN);
    assign bus.sel_active_out = sel_active;
    assign bus.sel_busy_out   = pend;
    assign bus.sel_err_out    = sel_err;
endmodule

// File: tb/tb_adc_rate_gen.sv
// Bench for adc_rate_gen: directed scenarios plus random run/rate traffic,
// every cycle compared against a period-position reference model.
module tb_adc_rate_gen;
    localparam int BASE_DIV  = 10;
    localparam int NUM_RATES = 8;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rst6;

    always #5 clk_in = ~clk_in;

    adc_rate_if #(.SEL_W(3)) bus ();
    adc_rate_if #(.SEL_W(3)) bus6 ();

    adc_rate_gen #(.BASE_DIV(BASE_DIV), .NUM_RATES(NUM_RATES)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    adc_rate_gen #(.BASE_DIV(BASE_DIV), .NUM_RATES(6)) dut6 (
        .clk_in (clk_in),
        .rst_in (rst6),
        .bus    (bus6)
    );

    int checks = 0;
    int errors = 0;

    // Reference: position within the current period plus select bookkeeping.
    int m_run = 0, m_pos = 0, m_act = 0, m_pend = 0, m_pv = 0, m_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rs, input bit en, input bit ld, input int sel);
        int div;
        bit apply;
        if (rs) begin
            m_run = 0; m_pos = 0; m_act = 0; m_pend = 0; m_pv = 0; m_err = 0;
        end else begin
            div   = BASE_DIV << m_act;
            apply = 0;
            m_err = (ld && sel >= NUM_RATES) ? 1 : 0;
            if (m_run == 0) begin
                apply = (m_pv != 0);
                if (en) begin
                    m_run = 1;
                    m_pos = 0;
                end
            end else if (m_pos == div - 1) begin
                apply = (m_pv != 0);
                m_pos = 0;
                if (!en) m_run = 0;
            end else begin
                m_pos++;
            end
            if (apply) begin
                m_act = m_pend;
                m_pv  = 0;
            end
            if (ld && sel < NUM_RATES) begin
                m_pend = sel;
                m_pv   = 1;
            end
        end
    endtask

    task automatic check_model();
        int div;
        int e_adc, e_stb;
        div   = BASE_DIV << m_act;
        e_adc = (m_run != 0 && m_pos < div / 2) ? 1 : 0;
        e_stb = (m_run != 0 && m_pos == 0) ? 1 : 0;
        chk("m_adc_clk",    32'(bus.adc_clk_out),    32'(e_adc));
        chk("m_sample_stb", 32'(bus.sample_stb_out), 32'(e_stb));
        chk("m_running",    32'(bus.running_out),    32'(m_run));
        chk("m_sel_active", 32'(bus.sel_active_out), 32'(m_act));
        chk("m_sel_busy",   32'(bus.sel_busy_out),   32'(m_pv));
        chk("m_sel_err",    32'(bus.sel_err_out),    32'(m_err));
    endtask

    task automatic tick();
        bit rs, en, ld;
        int sel;
        rs  = rst_in;
        en  = bus.enable_in;
        ld  = bus.sel_load_in;
        sel = int'(bus.sel_in);
        @(posedge clk_in);
        model_step(rs, en, ld, sel);
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic load_main(input int sel);
        bus.sel_in      = 3'(sel);
        bus.sel_load_in = 1'b1;
        tick();
        bus.sel_load_in = 1'b0;
    endtask

    task automatic load6(input int sel);
        bus6.sel_in      = 3'(sel);
        bus6.sel_load_in = 1'b1;
        tick();
        bus6.sel_load_in = 1'b0;
    endtask

    initial begin
        bus.enable_in    = 1'b0;
        bus.sel_in       = '0;
        bus.sel_load_in  = 1'b0;
        bus6.enable_in   = 1'b0;
        bus6.sel_in      = '0;
        bus6.sel_load_in = 1'b0;
        rst_in = 1'b1;
        rst6   = 1'b1;
        ticks(2);
        chk("rst_adc",    32'(bus.adc_clk_out),    0);
        chk("rst_stb",    32'(bus.sample_stb_out), 0);
        chk("rst_run",    32'(bus.running_out),    0);
        chk("rst_active", 32'(bus.sel_active_out), 0);
        chk("rst_busy",   32'(bus.sel_busy_out),   0);
        chk("rst_err",    32'(bus.sel_err_out),    0);
        rst_in = 1'b0;
        rst6   = 1'b0;

        // Start at rate 0: strobes at 1, 11; high 1-5, low 6-10.
        bus.enable_in = 1'b1;
        tick();
        chk("t1_stb_c1", 32'(bus.sample_stb_out), 1);
        chk("t1_adc_c1", 32'(bus.adc_clk_out),    1);
        chk("t1_run_c1", 32'(bus.running_out),    1);
        ticks(4);
        chk("t1_adc_c5", 32'(bus.adc_clk_out), 1);
        tick();
        chk("t1_adc_c6", 32'(bus.adc_clk_out), 0);
        ticks(5);
        chk("t1_stb_c11", 32'(bus.sample_stb_out), 1);

        // Load rate 2 at cnt 3; switch at the next boundary.
        ticks(3);
        load_main(2);
        chk("t2_busy_c15", 32'(bus.sel_busy_out), 1);
        ticks(5);
        chk("t2_busy_c20", 32'(bus.sel_busy_out), 1);
        chk("t2_stb_c20",  32'(bus.sample_stb_out), 0);
        tick();
        chk("t2_stb_c21",    32'(bus.sample_stb_out), 1);
        chk("t2_active_c21", 32'(bus.sel_active_out), 2);
        chk("t2_busy_c21",   32'(bus.sel_busy_out),   0);
        ticks(19);
        chk("t2_adc_c40", 32'(bus.adc_clk_out), 1);
        tick();
        chk("t2_adc_c41", 32'(bus.adc_clk_out), 0);
        ticks(20);
        chk("t2_stb_c61", 32'(bus.sample_stb_out), 1);

        // Rate 1, drop enable mid-period: period completes, then idle.
        load_main(1);
        ticks(39);
        chk("t3_stb_new",    32'(bus.sample_stb_out), 1);
        chk("t3_active_new", 32'(bus.sel_active_out), 1);
        ticks(4);
        bus.enable_in = 1'b0;
        ticks(5);
        chk("t3_adc_last_high", 32'(bus.adc_clk_out), 1);
        tick();
        chk("t3_adc_first_low", 32'(bus.adc_clk_out), 0);
        ticks(9);
        chk("t3_run_at_bound", 32'(bus.running_out), 1);
        tick();
        chk("t3_run_idle", 32'(bus.running_out),    0);
        chk("t3_stb_idle", 32'(bus.sample_stb_out), 0);
        ticks(15);
        chk("t3_run_stays", 32'(bus.running_out), 0);

        // Load exactly at the boundary with nothing pending.
        load_main(0);
        tick();
        chk("t4_active0", 32'(bus.sel_active_out), 0);
        chk("t4_busy0",   32'(bus.sel_busy_out),   0);
        bus.enable_in = 1'b1;
        tick();
        chk("t4_stb_start", 32'(bus.sample_stb_out), 1);
        ticks(9);
        load_main(1);
        chk("t4_stb_b1",    32'(bus.sample_stb_out), 1);
        chk("t4_active_b1", 32'(bus.sel_active_out), 0);
        chk("t4_busy_b1",   32'(bus.sel_busy_out),   1);
        ticks(10);
        chk("t4_stb_b2",    32'(bus.sample_stb_out), 1);
        chk("t4_active_b2", 32'(bus.sel_active_out), 1);
        chk("t4_busy_b2",   32'(bus.sel_busy_out),   0);
        ticks(19);
        chk("t4_stb_mid", 32'(bus.sample_stb_out), 0);
        tick();
        chk("t4_stb_b3", 32'(bus.sample_stb_out), 1);

        // Reset while high with sel 3 pending.
        load_main(3);
        chk("t5_adc_pre",  32'(bus.adc_clk_out),  1);
        chk("t5_busy_pre", 32'(bus.sel_busy_out), 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("t5_adc",    32'(bus.adc_clk_out),    0);
        chk("t5_stb",    32'(bus.sample_stb_out), 0);
        chk("t5_run",    32'(bus.running_out),    0);
        chk("t5_active", 32'(bus.sel_active_out), 0);
        chk("t5_busy",   32'(bus.sel_busy_out),   0);
        bus.enable_in = 1'b0;
        ticks(3);

        // Six-rate instance: out-of-range loads are rejected.
        load6(7);
        chk("t6_err_pulse", 32'(bus6.sel_err_out),    1);
        chk("t6_active",    32'(bus6.sel_active_out), 0);
        chk("t6_busy",      32'(bus6.sel_busy_out),   0);
        tick();
        chk("t6_err_clear", 32'(bus6.sel_err_out), 0);
        load6(5);
        chk("t6_busy5", 32'(bus6.sel_busy_out), 1);
        chk("t6_err5",  32'(bus6.sel_err_out),  0);
        tick();
        chk("t6_active5", 32'(bus6.sel_active_out), 5);
        load6(6);
        chk("t6_err6",        32'(bus6.sel_err_out),    1);
        chk("t6_active_keep", 32'(bus6.sel_active_out), 5);
        chk("t6_busy_keep",   32'(bus6.sel_busy_out),   0);
        tick();
        chk("t6_err6_clear", 32'(bus6.sel_err_out), 0);

        // Random enable/load/reset traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.enable_in = ~bus.enable_in;
            bus.sel_load_in = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0)
                bus.sel_in = 3'($urandom_range(4, 7));
            else
                bus.sel_in = 3'($urandom_range(0, 3));
            rst_in = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
